// File: rtl/ad_framer_pkg.sv
// Shared types, constants and the double-dabble step helper for the ADC-to-ASCII framer.
package ad_framer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam int         FRAME_LEN  = 6;
    localparam int         ADC_W      = 12;
    localparam int         BCD_DIGITS = 4;
    localparam int         BCD_W      = 4 * BCD_DIGITS;
    localparam int         SHIFT_W    = BCD_W + ADC_W;

    // One double-dabble iteration on {bcd, bin}: correct every digit >= 5, then shift left.
    function automatic logic [SHIFT_W-1:0] dabble_step(input logic [SHIFT_W-1:0] v);
        logic [SHIFT_W-1:0] t;
        t = v;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (t[ADC_W + 4*d +: 4] >= 4'd5) begin
                t[ADC_W + 4*d +: 4] = t[ADC_W + 4*d +: 4] + 4'd3;
            end else begin
                t[ADC_W + 4*d +: 4] = t[ADC_W + 4*d +: 4];
            end
        end
        return {t[SHIFT_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/ad_ascii_framer_bin2bcd_seq.sv
// Sequential 12-bit binary to 4-digit BCD converter; one double-dabble step per cycle.
module bin2bcd_seq
    import ad_framer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ADC_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [SHIFT_W-1:0] shift_r;
    logic [SHIFT_W-1:0] step_s;
    logic [3:0]         cnt_r;
    logic               busy_r;

    // done fires in the final step cycle and bcd carries that step's result, so the
    // consumer can register the answer on the same edge the last shift would occur.
    always_comb begin
        step_s = dabble_step(shift_r);
        done   = busy_r && (cnt_r == 4'(ADC_W - 1));
        bcd    = step_s[SHIFT_W-1:ADC_W];
        busy   = busy_r;
    end

    // Shift register, step counter and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= '0;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
        end else if (start) begin
            shift_r <= {{BCD_W{1'b0}}, bin};
            cnt_r   <= 4'd0;
            busy_r  <= 1'b1;
        end else if (busy_r) begin
            shift_r <= step_s;
            cnt_r   <= cnt_r + 4'd1;
            busy_r  <= (cnt_r != 4'(ADC_W - 1));
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
            busy_r  <= 1'b0;
        end
    end

endmodule

// File: rtl/ad_ascii_framer.sv
// Periodically reports the ADC sample as "dddd\r\n" over a valid/ready byte stream.
// Optional build macro AD_FRAMER_AVG_EN reports the 16-sample mean instead of the latest sample.
module ad_ascii_framer
    import ad_framer_pkg::*;
#(
    parameter int CLK_FRE  = 50,
    parameter int SEND_FRE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] ad9220_data,
    input  logic        ad9220_data_valid,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready
);

    localparam int TICK_CYCLES = CLK_FRE * 1000000 / SEND_FRE;
    localparam int CNT_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    logic [CNT_W-1:0] tick_cnt_r;
    logic             tick_s;
    logic [ADC_W-1:0] sample_r;
    state_t           state_r, state_next;
    logic [2:0]       idx_r, idx_next;
    logic [BCD_W-1:0] digits_r, digits_next;
    logic [7:0]       tx_data_r, tx_data_next;
    logic             tx_valid_r, tx_valid_next;
    logic             conv_start_s, conv_busy_s, conv_done_s;
    logic [BCD_W-1:0] conv_bcd_s;

    function automatic logic [7:0] frame_byte(input logic [BCD_W-1:0] d, input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = ASCII_ZERO + {4'h0, d[15:12]};
            3'd1:    b = ASCII_ZERO + {4'h0, d[11:8]};
            3'd2:    b = ASCII_ZERO + {4'h0, d[7:4]};
            3'd3:    b = ASCII_ZERO + {4'h0, d[3:0]};
            3'd4:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

    assign tick_s        = (tick_cnt_r == CNT_W'(TICK_CYCLES - 1));
    assign tx_data       = tx_data_r;
    assign tx_data_valid = tx_valid_r;

    // Free-running report-rate counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + CNT_W'(1);
        end
    end

`ifdef AD_FRAMER_AVG_EN
    logic [15:0] acc_r;
    logic [3:0]  avg_cnt_r;
    logic [15:0] sum_s;

    assign sum_s = acc_r + {4'h0, ad9220_data};

    // Block-of-16 averager; the sample register only changes when a block completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= 16'd0;
            avg_cnt_r <= 4'd0;
            sample_r  <= '0;
        end else if (ad9220_data_valid && (avg_cnt_r == 4'd15)) begin
            acc_r     <= 16'd0;
            avg_cnt_r <= 4'd0;
            sample_r  <= sum_s[15:4];
        end else if (ad9220_data_valid) begin
            acc_r     <= sum_s;
            avg_cnt_r <= avg_cnt_r + 4'd1;
            sample_r  <= sample_r;
        end else begin
            acc_r     <= acc_r;
            avg_cnt_r <= avg_cnt_r;
            sample_r  <= sample_r;
        end
    end
`else
    // Latest-sample register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_r <= '0;
        end else if (ad9220_data_valid) begin
            sample_r <= ad9220_data;
        end else begin
            sample_r <= sample_r;
        end
    end
`endif

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start_s),
        .bin   (sample_r),
        .busy  (conv_busy_s),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s)
    );

    // Frame FSM next-state and registered-output logic.
    always_comb begin
        state_next    = state_r;
        idx_next      = idx_r;
        digits_next   = digits_r;
        tx_data_next  = tx_data_r;
        tx_valid_next = tx_valid_r;
        conv_start_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (tick_s) begin
                    conv_start_s = 1'b1;
                    state_next   = CONV;
                end else begin
                    state_next   = IDLE;
                end
            end
            CONV: begin
                if (conv_done_s) begin
                    digits_next   = conv_bcd_s;
                    idx_next      = 3'd0;
                    tx_data_next  = frame_byte(conv_bcd_s, 3'd0);
                    tx_valid_next = 1'b1;
                    state_next    = SEND;
                end else if (!conv_busy_s) begin
                    state_next    = IDLE;
                end else begin
                    state_next    = CONV;
                end
            end
            SEND: begin
                if (tx_valid_r && tx_data_ready && (idx_r == LAST_IDX)) begin
                    tx_valid_next = 1'b0;
                    tx_data_next  = 8'h00;
                    idx_next      = 3'd0;
                    state_next    = IDLE;
                end else if (tx_valid_r && tx_data_ready) begin
                    idx_next      = idx_r + 3'd1;
                    tx_data_next  = frame_byte(digits_r, idx_r + 3'd1);
                end else begin
                    state_next    = SEND;
                end
            end
            default: begin
                state_next    = IDLE;
                tx_valid_next = 1'b0;
                tx_data_next  = 8'h00;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            idx_r      <= 3'd0;
            digits_r   <= '0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else begin
            state_r    <= state_next;
            idx_r      <= idx_next;
            digits_r   <= digits_next;
            tx_data_r  <= tx_data_next;
            tx_valid_r <= tx_valid_next;
        end
    end

endmodule

// File: tb/tb_ad_ascii_framer.sv
// Scoreboard bench for ad_ascii_framer with a 1000-cycle report period.
module tb_ad_ascii_framer;
    localparam int TICK = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] ad9220_data;
    logic        ad9220_data_valid;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;

    logic [7:0]  q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          frame_xfers = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    ad_ascii_framer #(.CLK_FRE(1), .SEND_FRE(1000)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ad9220_data       (ad9220_data),
        .ad9220_data_valid (ad9220_data_valid),
        .tx_data           (tx_data),
        .tx_data_valid     (tx_data_valid),
        .tx_data_ready     (tx_data_ready)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; the framer's tick lands where cyc % TICK == TICK-1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_frame(input int v);
        q.push_back(8'h30 + 8'(v / 1000));
        q.push_back(8'h30 + 8'((v / 100) % 10));
        q.push_back(8'h30 + 8'((v / 10) % 10));
        q.push_back(8'h30 + 8'(v % 10));
        q.push_back(8'h0D);
        q.push_back(8'h0A);
    endfunction

    // Monitor: pops the scoreboard on each transfer and checks handshake rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid  = 1'b0;
            prev_ready  = 1'b0;
            frame_xfers = 0;
        end else begin
            if (prev_valid && !prev_ready)
                check(tx_data_valid && (tx_data == prev_data), "stall_stable", {23'd0, tx_data_valid, tx_data}, {24'd1, prev_data});
            if (tx_data_valid && !prev_valid)
                check((cyc % TICK) == 12, "first_byte_latency", cyc % TICK, 12);
            if (!tx_data_valid && prev_valid) begin
                check(frame_xfers == 6, "frame_length", frame_xfers, 6);
                frame_xfers = 0;
            end
            if (tx_data_valid && tx_data_ready) begin
                frame_xfers++;
                if (q.size() == 0) begin
                    check(1'b0, "unexpected_byte", tx_data, 0);
                end else begin
                    logic [7:0] e;
                    e = q.pop_front();
                    check(tx_data == e, "byte", tx_data, e);
                end
            end
            prev_valid = tx_data_valid;
            prev_ready = tx_data_ready;
            prev_data  = tx_data;
        end
    end

    task automatic strobe(input logic [11:0] v);
        @(posedge clk); #2;
        ad9220_data = v;
        ad9220_data_valid = 1'b1;
        @(posedge clk); #2;
        ad9220_data_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input bit rand_ready, input string name);
        int n = 0;
        while ((q.size() != 0 || tx_data_valid) && n < budget) begin
            @(posedge clk); #1;
            if (rand_ready) tx_data_ready = ($urandom_range(0, 99) < 30);
            n++;
        end
        check(n < budget, name, n, budget);
        if (n >= budget) q.delete();
        tx_data_ready = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        tx_data_ready = 1'b0;
        ad9220_data = 12'd0;
        ad9220_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(tx_data == 8'h00, "reset_tx_data", tx_data, 8'h00);
        check(tx_data_valid == 1'b0, "reset_tx_valid", tx_data_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_data_ready = 1'b1;
`ifdef AD_FRAMER_AVG_EN
        for (int i = 0; i < 16; i++) strobe(12'(100 + i));
        push_frame(107);
        drain(1500, 1'b0, "avg_frame_timeout");
`else
        strobe(12'd1234);
        push_frame(1234);
        drain(1500, 1'b0, "frame_1234_timeout");
        strobe(12'd0);
        push_frame(0);
        drain(1200, 1'b0, "frame_0_timeout");
        strobe(12'd4095);
        push_frame(4095);
        drain(1200, 1'b0, "frame_4095_timeout");

        strobe(12'd2748);
        push_frame(2748);
        drain(1500, 1'b1, "random_ready_timeout");

        // Stall longer than two report periods; later ticks and strobes must not alter the frame.
        tx_data_ready = 1'b0;
        strobe(12'd567);
        push_frame(567);
        n = 0;
        while (!tx_data_valid && n < 1200) begin @(posedge clk); #1; n++; end
        check(n < 1200, "stall_frame_start", n, 1200);
        strobe(12'd999);
        repeat (2500) @(posedge clk);
        #1;
        check(tx_data_valid && tx_data == 8'h30, "held_first_byte", {23'd0, tx_data_valid, tx_data}, {24'd1, 8'h30});
        tx_data_ready = 1'b1;
        drain(100, 1'b0, "stall_release_timeout");
        push_frame(999);
        drain(1200, 1'b0, "frame_999_timeout");

        // Reset in the middle of a frame.
        strobe(12'd3210);
        push_frame(3210);
        n = 0;
        while (frame_xfers < 2 && n < 1200) begin @(posedge clk); #1; n++; end
        check(n < 1200, "mid_frame_wait", n, 1200);
        rst_n = 1'b0;
        #1;
        check(tx_data_valid == 1'b0, "abort_valid", tx_data_valid, 0);
        check(tx_data == 8'h00, "abort_data", tx_data, 8'h00);
        q.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        strobe(12'd3210);
        push_frame(3210);
        drain(1200, 1'b0, "post_reset_frame_timeout");
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
